// File: rtl/dc_offset_remover.sv
// dc_offset_remover: subtracts a leaky-integrator DC estimate from a signed
// sample stream and saturates the result to the stream width.
//
// Ports:
//   i_clk, i_resetn   clock, asynchronous active-low reset
//   iS_data, i_valid  signed input sample and its qualifier (no backpressure)
//   i_acq_restart     pulse that returns the estimator to SEED
//   oS_data, o_valid  registered DC-removed sample and its qualifier
//   o_locked          high while the estimator is in slow tracking
//   o_clip            high for an output sample that saturated; present only
//                     when DC_OFFSET_CLIP_FLAG_EN is defined
//
// Estimator phases: SEED loads the first sample, FAST converges with a
// short leak shift for ACQ_SAMPLES samples, TRACK follows with the long one.
module dc_offset_remover #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT       = 10,
  parameter int FAST_SHIFT  = 3,
  parameter int ACQ_SAMPLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic [DATA_WIDTH-1:0] iS_data,
  input  logic                  i_valid,
  input  logic                  i_acq_restart,
  output logic [DATA_WIDTH-1:0] oS_data,
  output logic                  o_valid,
  output logic                  o_locked
`ifdef DC_OFFSET_CLIP_FLAG_EN
  ,
  output logic                  o_clip
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = DATA_WIDTH + SHIFT + 1;
  localparam int DS = SHIFT - FAST_SHIFT;
  localparam int CW = $clog2(ACQ_SAMPLES + 1);

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    FAST  = 2'd1,
    TRACK = 2'd2
  } state_e;

  state_e        state_q;
  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          locked_q;
`ifdef DC_OFFSET_CLIP_FLAG_EN
  logic          clip_q;
`endif

  // Floor of acc / 2^SHIFT is simply its upper DW+1 bits.
  logic [DW:0]   est;
  logic [DW:0]   x_e;
  logic [DW:0]   err;
  logic          ovf;
  logic [DW-1:0] sat;
  logic [AW-1:0] err_x;
  logic [AW-1:0] seed_v;
  logic [CW-1:0] cnt_d;
  logic          acq_done;
  logic          do_seed;
  logic          do_fast;
  logic          do_track;

  always_comb begin
    est      = acc_q[AW-1:SHIFT];
    x_e      = {iS_data[DW-1], iS_data};
    err      = x_e - est;
    // Two top bits disagree: difference does not fit in DW bits.
    ovf      = err[DW] ^ err[DW-1];
    sat      = ovf ? {err[DW], {(DW-1){~err[DW]}}}
                   : err[DW-1:0];
    err_x    = {{SHIFT{err[DW]}}, err};
    seed_v   = {iS_data[DW-1], iS_data, {SHIFT{1'b0}}};
    cnt_d    = cnt_q + CW'(1);
    acq_done = (cnt_d == CW'(ACQ_SAMPLES));
    // Restart wins over any state for the sample it coincides with.
    do_seed  = i_acq_restart || (state_q == SEED);
    do_fast  = !i_acq_restart && (state_q == FAST);
    do_track = !i_acq_restart && (state_q == TRACK);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q  <= SEED;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
`ifdef DC_OFFSET_CLIP_FLAG_EN
      clip_q   <= 1'b0;
`endif
    end else begin
      valid_q <= i_valid;
`ifdef DC_OFFSET_CLIP_FLAG_EN
      clip_q  <= 1'b0;
`endif
      if (i_valid) begin
        unique case (1'b1)
          do_seed: begin
            acc_q    <= seed_v;
            cnt_q    <= '0;
            data_q   <= '0;
            state_q  <= FAST;
            locked_q <= 1'b0;
          end
          do_fast: begin
            acc_q    <= acc_q + (err_x << DS);
            cnt_q    <= cnt_d;
            data_q   <= sat;
`ifdef DC_OFFSET_CLIP_FLAG_EN
            clip_q   <= ovf;
`endif
            if (acq_done) begin
              state_q  <= TRACK;
              locked_q <= 1'b1;
            end
          end
          do_track: begin
            acc_q    <= acc_q + err_x;
            data_q   <= sat;
`ifdef DC_OFFSET_CLIP_FLAG_EN
            clip_q   <= ovf;
`endif
          end
          default: begin
            state_q  <= SEED;
            locked_q <= 1'b0;
          end
        endcase
      end else if (i_acq_restart) begin
        state_q  <= SEED;
        locked_q <= 1'b0;
      end
    end
  end

  assign oS_data  = data_q;
  assign o_valid  = valid_q;
  assign o_locked = locked_q;
`ifdef DC_OFFSET_CLIP_FLAG_EN
  assign o_clip   = clip_q;
`endif

endmodule

// File: tb/tb_dc_offset_remover.sv
// tb_dc_offset_remover: scoreboard bench for dc_offset_remover.
// A behavioural estimator predicts each output; the monitor pops and compares.
module tb_dc_offset_remover;

  localparam int DW  = 16;
  localparam int SH  = 4;
  localparam int FSH = 1;
  localparam int ACQ = 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          vin;
  logic          rstrt;
  logic [DW-1:0] dout;
  logic          vout;
  logic          lock;
  logic          clip;

  dc_offset_remover #(
    .DATA_WIDTH (DW),
    .SHIFT      (SH),
    .FAST_SHIFT (FSH),
    .ACQ_SAMPLES(ACQ)
  ) dut (
    .i_clk        (clk),
    .i_resetn     (rst_n),
    .iS_data      (din),
    .i_valid      (vin),
    .i_acq_restart(rstrt),
    .oS_data      (dout),
    .o_valid      (vout),
    .o_locked     (lock)
`ifdef DC_OFFSET_CLIP_FLAG_EN
    ,
    .o_clip       (clip)
`endif
  );

`ifndef DC_OFFSET_CLIP_FLAG_EN
  assign clip = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint d;
    bit     lk;
    bit     cl;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   exp_vld = 1'b0;
  bit   exp_lock = 1'b0;

  // model state: 0 seed, 1 fast, 2 track
  int     m_st = 0;
  longint m_acc = 0;
  int     m_cnt = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_acc = 0;
    m_cnt = 0;
  endtask

  task automatic drive(input bit v, input int x, input bit r);
    exp_t   e;
    longint est;
    longint err;
    @(negedge clk);
    vin   = v;
    din   = DW'(x);
    rstrt = r;
    if (r && !v) m_st = 0;
    if (v) begin
      if (r || m_st == 0) begin
        m_acc = longint'(x) * (longint'(1) << SH);
        m_cnt = 0;
        m_st  = 1;
        e.d   = 0;
        e.cl  = 1'b0;
      end else begin
        est  = fdiv(m_acc, longint'(1) << SH);
        err  = longint'(x) - est;
        e.cl = (err > 32767) || (err < -32768);
        e.d  = (err > 32767) ? 32767 : (err < -32768) ? -32768 : err;
        if (m_st == 1) begin
          m_acc = m_acc + err * (longint'(1) << (SH - FSH));
          m_cnt++;
          if (m_cnt == ACQ) m_st = 2;
        end else begin
          m_acc = m_acc + err;
        end
      end
      e.lk = (m_st == 2);
      q.push_back(e);
    end
    exp_vld  = v;
    exp_lock = (m_st == 2);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    chk("o_valid", longint'(vout), longint'(exp_vld));
    chk("o_locked", longint'(lock), longint'(exp_lock));
    if (vout) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("oS_data", longint'($signed(dout)), e.d);
        chk("lock_at_out", longint'(lock), longint'(e.lk));
`ifdef DC_OFFSET_CLIP_FLAG_EN
        chk("o_clip", longint'(clip), longint'(e.cl));
`endif
      end
    end else begin
`ifdef DC_OFFSET_CLIP_FLAG_EN
      chk("o_clip_idle", longint'(clip), 0);
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    din   = '0;
    vin   = 1'b0;
    rstrt = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    chk("rst_data", longint'(dout), 0);
    chk("rst_valid", longint'(vout), 0);
    chk("rst_lock", longint'(lock), 0);
    chk("rst_clip", longint'(clip), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0);

    // constant input, lock after seed + ACQ samples
    for (int i = 0; i < 12; i++) drive(1, 1000, 0);
    // step to 2000: 1000, 938, then decaying
    for (int i = 0; i < 20; i++) drive(1, 2000, 0);
    drive(0, 0, 0);

    // saturation after restart without valid
    drive(0, 0, 1);
    drive(1, -30000, 0);
    drive(1, 32767, 0);
    drive(1, 0, 0);
    drive(1, 100, 0);
    drive(0, 0, 0);
    drive(1, -32768, 0);
    drive(0, 0, 0);

    // gapped valid, lock counts samples not clocks
    drive(0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      drive(1, 500, 0);
      @(posedge clk);
      #2;
      chk("gap_lock", longint'(lock), (i >= ACQ) ? 1 : 0);
      drive(0, 0, 0);
      drive(0, 0, 0);
    end

    // restart colliding with valid while locked
    drive(1, 1234, 1);
    for (int i = 0; i < 6; i++) drive(1, 1234, 0);

    // ramp with an asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) drive(1, 100 + i, 0);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    vin      = 1'b0;
    exp_vld  = 1'b0;
    exp_lock = 1'b0;
    model_reset();
    #1;
    chk("midrst_data", longint'(dout), 0);
    chk("midrst_valid", longint'(vout), 0);
    chk("midrst_lock", longint'(lock), 0);
    drive(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive(1, 200 + i, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);

    chk("queue_drain", longint'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
